// File: rtl/sparc_ifu_thrpick_pkg.sv
// Shared IFU thread-FSM encodings and decode bit positions for the thread picker.
package sparc_ifu_thrpick_pkg;

  localparam int unsigned THR_N  = 4;  // threads per core
  localparam int unsigned THR_SW = 5;  // thread FSM state width
  localparam int unsigned THR_IW = 2;  // thread index width

  // Thread FSM state encodings
  localparam logic [THR_SW-1:0] THRFSM_IDLE     = 5'b00000;
  localparam logic [THR_SW-1:0] THRFSM_HALT     = 5'b00010;
  localparam logic [THR_SW-1:0] THRFSM_WAIT     = 5'b00001;
  localparam logic [THR_SW-1:0] THRFSM_RDY      = 5'b11001;
  localparam logic [THR_SW-1:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [THR_SW-1:0] THRFSM_RUN      = 5'b00101;
  localparam logic [THR_SW-1:0] THRFSM_SPEC_RUN = 5'b00111;

  // Decode bit positions within a state word
  localparam int unsigned THR_RDY_BIT     = 4;
  localparam int unsigned THR_RUN_BIT     = 2;
  localparam int unsigned THR_SPEC_BIT    = 1;
  localparam int unsigned THR_SPEC_LO_BIT = 0;

endpackage

// File: rtl/sparc_ifu_rrpick4.sv
// Combinational 4-way rotating-priority picker: first request at or above i_ptr, modulo 4.
module sparc_ifu_rrpick4
  import sparc_ifu_thrpick_pkg::*;
(
  input  logic [THR_N-1:0]  i_req,
  input  logic [THR_IW-1:0] i_ptr,
  output logic [THR_N-1:0]  o_grant,
  output logic [THR_IW-1:0] o_idx
);

  logic              w_found;
  logic [THR_IW-1:0] w_j;

  // Scan from i_ptr upward, wrapping, and grant the first requester.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < THR_N; k++) begin
      w_j = i_ptr + THR_IW'(k);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparc_ifu_thrpick.sv
// Per-core thread picker: idle picks, quantum-forced switches, LRU pointer, non-speculative preference.
module sparc_ifu_thrpick
  import sparc_ifu_thrpick_pkg::*;
#(
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned QW      = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [THR_SW-1:0] thr_state0,
  input  logic [THR_SW-1:0] thr_state1,
  input  logic [THR_SW-1:0] thr_state2,
  input  logic [THR_SW-1:0] thr_state3,
  input  logic              hold,
  output logic [THR_N-1:0]  schedule,
  output logic              switch_out,
  output logic [THR_N-1:0]  cur_thr
);

  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  logic [THR_N-1:0][THR_SW-1:0] w_state;
  logic [THR_N-1:0]  w_rdy, w_spec, w_run;
  logic [THR_N-1:0]  w_cand, w_cand_ns, w_cand_sp;
  logic [THR_N-1:0]  w_grant_ns, w_grant_sp, w_grant;
  logic [THR_IW-1:0] w_idx_ns, w_idx_sp, w_idx;
  logic              w_qsat, w_pick_idle, w_pick_force, w_pick;

  logic [THR_N-1:0]  r_cur_thr;
  logic [THR_IW-1:0] r_ptr;
  logic [QW-1:0]     r_qcnt;

  assign w_state = {thr_state3, thr_state2, thr_state1, thr_state0};

  // Decode ready / speculative / running bits per thread.
  always_comb begin
    w_rdy  = '0;
    w_spec = '0;
    w_run  = '0;
    for (int i = 0; i < THR_N; i++) begin
      w_rdy[i]  = w_state[i][THR_RDY_BIT];
      w_spec[i] = w_state[i][THR_SPEC_BIT] & w_state[i][THR_SPEC_LO_BIT] & ~w_state[i][THR_RUN_BIT];
      w_run[i]  = w_state[i][THR_RUN_BIT];
    end
  end

  assign w_cand    = w_rdy & ~w_run;
  assign w_cand_ns = w_cand & ~w_spec;
  assign w_cand_sp = w_cand & w_spec;

  sparc_ifu_rrpick4 u_pick_ns (
    .i_req   (w_cand_ns),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_ns),
    .o_idx   (w_idx_ns)
  );

  sparc_ifu_rrpick4 u_pick_sp (
    .i_req   (w_cand_sp),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_sp),
    .o_idx   (w_idx_sp)
  );

  // Speculative-ready threads only compete when no non-speculative one is ready.
  assign w_grant = (|w_cand_ns) ? w_grant_ns : w_grant_sp;
  assign w_idx   = (|w_cand_ns) ? w_idx_ns   : w_idx_sp;

  assign w_qsat       = (r_qcnt == QMAX);
  assign w_pick_idle  = !hold && (w_run == '0) && (|w_cand);
  assign w_pick_force = !hold && $onehot(w_run) && w_qsat && (|w_cand);
  assign w_pick       = w_pick_idle || w_pick_force;

  // Outputs feed the FSMs combinationally and are gated off while reset is high.
  assign schedule   = (w_pick && !reset) ? w_grant : '0;
  assign switch_out = w_pick_force && !reset;
  assign cur_thr    = r_cur_thr;

  // Last-scheduled thread, priority pointer and run-quantum counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_thr <= '0;
      r_ptr     <= '0;
      r_qcnt    <= '0;
    end else if (w_pick) begin
      r_cur_thr <= w_grant;
      r_ptr     <= w_idx + THR_IW'(1);
      r_qcnt    <= '0;
    end else if (!hold && (w_run != '0) && !w_qsat) begin
      r_qcnt    <= r_qcnt + QW'(1);
    end
  end

`ifndef SYNTHESIS
  // Flag more than one running thread and malformed ready encodings.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($countones(w_run) <= 1)
        else $error("sparc_ifu_thrpick: more than one thread in RUN (%b)", w_run);
      for (int i = 0; i < THR_N; i++) begin
        assert (!w_state[i][THR_RDY_BIT] || (w_state[i] == THRFSM_RDY) ||
                (w_state[i] == THRFSM_SPEC_RDY))
          else $error("sparc_ifu_thrpick: bad ready encoding on thread %0d (%b)", i, w_state[i]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sparc_ifu_thrpick.sv
// Directed self-checking bench for the thread picker; thread FSMs are emulated by hand.
module tb_sparc_ifu_thrpick;
  import sparc_ifu_thrpick_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] st0, st1, st2, st3;
  logic       hold;
  logic [3:0] schedule;
  logic       switch_out;
  logic [3:0] cur_thr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sparc_ifu_thrpick #(.QUANTUM(16), .QW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .thr_state0 (st0),
    .thr_state1 (st1),
    .thr_state2 (st2),
    .thr_state3 (st3),
    .hold       (hold),
    .schedule   (schedule),
    .switch_out (switch_out),
    .cur_thr    (cur_thr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
    st0 = a; st1 = b; st2 = c; st3 = d;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold  = 1'b0;
    set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0000) begin
      errors++; $display("FAIL reset_gate: got %b want %b", {switch_out, schedule}, 5'b0_0000);
    end
    checks++;
    if (cur_thr !== 4'b0000) begin
      errors++; $display("FAIL reset_cur: got %b want %b", cur_thr, 4'b0000);
    end
    set_st(THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({switch_out, schedule, cur_thr} !== 9'b0_0000_0000) begin
        errors++; $display("FAIL idle_quiet c%0d: got %b want %b", c, {switch_out, schedule, cur_thr}, 9'b0);
      end
      tick();
    end
  endtask

  task automatic test_idle_pick();
    set_st(THRFSM_IDLE, THRFSM_IDLE, THRFSM_RDY, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0100) begin
      errors++; $display("FAIL idle_pick_t2: got %b want %b", {switch_out, schedule}, 5'b0_0100);
    end
    tick();
    checks++;
    if (cur_thr !== 4'b0100) begin
      errors++; $display("FAIL idle_pick_cur: got %b want %b", cur_thr, 4'b0100);
    end
    // T2 leaves on its own; with ptr=3 the T3 candidate must beat T0.
    set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_WAIT, THRFSM_RDY);
    checks++;
    if ({switch_out, schedule} !== 5'b0_1000) begin
      errors++; $display("FAIL ptr_after_t2: got %b want %b", {switch_out, schedule}, 5'b0_1000);
    end
    tick();
    checks++;
    if (cur_thr !== 4'b1000) begin
      errors++; $display("FAIL cur_t3: got %b want %b", cur_thr, 4'b1000);
    end
    set_st(THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    tick();
  endtask

  task automatic test_quantum();
    // ptr=0, qcnt=0
    set_st(THRFSM_RUN, THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE);
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if ({switch_out, schedule} !== 5'b0_0000) begin
        errors++; $display("FAIL quantum_t0_early c%0d: got %b want %b", c, {switch_out, schedule}, 5'b0);
      end
      tick();
    end
    checks++;
    if ({switch_out, schedule} !== 5'b1_0010) begin
      errors++; $display("FAIL quantum_t0_force: got %b want %b", {switch_out, schedule}, 5'b1_0010);
    end
    tick();
    // ptr=2, qcnt cleared: T1 runs a full quantum before T0 is switched back in.
    set_st(THRFSM_RDY, THRFSM_RUN, THRFSM_IDLE, THRFSM_IDLE);
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if ({switch_out, schedule} !== 5'b0_0000) begin
        errors++; $display("FAIL quantum_t1_early c%0d: got %b want %b", c, {switch_out, schedule}, 5'b0);
      end
      tick();
    end
    checks++;
    if ({switch_out, schedule} !== 5'b1_0001) begin
      errors++; $display("FAIL quantum_t1_force: got %b want %b", {switch_out, schedule}, 5'b1_0001);
    end
    tick();
    checks++;
    if (cur_thr !== 4'b0001) begin
      errors++; $display("FAIL quantum_cur: got %b want %b", cur_thr, 4'b0001);
    end
    // ptr=1: nobody ready, so the saturated counter must not cause a switch.
    set_st(THRFSM_RUN, THRFSM_WAIT, THRFSM_IDLE, THRFSM_IDLE);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({switch_out, schedule} !== 5'b0_0000) begin
        errors++; $display("FAIL sat_no_cand c%0d: got %b want %b", c, {switch_out, schedule}, 5'b0);
      end
      tick();
    end
    set_st(THRFSM_RUN, THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b1_0010) begin
      errors++; $display("FAIL sat_then_rdy: got %b want %b", {switch_out, schedule}, 5'b1_0010);
    end
    tick();
    set_st(THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    tick();
  endtask

  task automatic test_spec_pref();
    // ptr=2: pick T0 to bring ptr to 1.
    set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0001) begin
      errors++; $display("FAIL spec_setup: got %b want %b", {switch_out, schedule}, 5'b0_0001);
    end
    tick();
    set_st(THRFSM_IDLE, THRFSM_SPEC_RDY, THRFSM_IDLE, THRFSM_RDY);
    checks++;
    if ({switch_out, schedule} !== 5'b0_1000) begin
      errors++; $display("FAIL spec_nonspec_pref: got %b want %b", {switch_out, schedule}, 5'b0_1000);
    end
    set_st(THRFSM_IDLE, THRFSM_SPEC_RDY, THRFSM_IDLE, THRFSM_WAIT);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0010) begin
      errors++; $display("FAIL spec_only: got %b want %b", {switch_out, schedule}, 5'b0_0010);
    end
    tick();
    checks++;
    if (cur_thr !== 4'b0010) begin
      errors++; $display("FAIL spec_cur: got %b want %b", cur_thr, 4'b0010);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001;
    // ptr=2: pick T3 so ptr wraps to 0.
    set_st(THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE, THRFSM_RDY);
    checks++;
    if ({switch_out, schedule} !== 5'b0_1000) begin
      errors++; $display("FAIL rr_setup: got %b want %b", {switch_out, schedule}, 5'b0_1000);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_RDY, THRFSM_IDLE);
      checks++;
      if ({switch_out, schedule} !== {1'b0, exp_g[i]}) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", i, {switch_out, schedule}, {1'b0, exp_g[i]});
      end
      tick();
      checks++;
      if (cur_thr !== exp_g[i]) begin
        errors++; $display("FAIL rr_cur%0d: got %b want %b", i, cur_thr, exp_g[i]);
      end
      if (exp_g[i] == 4'b0001) set_st(THRFSM_RUN, THRFSM_IDLE, THRFSM_RDY, THRFSM_IDLE);
      else                     set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_RUN, THRFSM_IDLE);
      checks++;
      if ({switch_out, schedule} !== 5'b0_0000) begin
        errors++; $display("FAIL rr_run%0d: got %b want %b", i, {switch_out, schedule}, 5'b0);
      end
      tick();
    end
  endtask

  task automatic test_hold_and_reset();
    // ptr=1: fresh pick of T0 clears qcnt.
    set_st(THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0001) begin
      errors++; $display("FAIL hold_setup: got %b want %b", {switch_out, schedule}, 5'b0_0001);
    end
    tick();
    set_st(THRFSM_RUN, THRFSM_IDLE, THRFSM_RDY, THRFSM_IDLE);
    for (int c = 0; c < 10; c++) tick();
    // qcnt=10; hold must freeze it.
    hold = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({switch_out, schedule, cur_thr} !== 9'b0_0000_0001) begin
        errors++; $display("FAIL hold_mid c%0d: got %b want %b", c, {switch_out, schedule, cur_thr}, 9'b0_0000_0001);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({switch_out, schedule} !== 5'b0_0000) begin
        errors++; $display("FAIL hold_resume c%0d: got %b want %b", c, {switch_out, schedule}, 5'b0);
      end
      tick();
    end
    // Switch is due now; hold suppresses it.
    hold = 1'b1;
    #1;
    checks++;
    if ({switch_out, schedule} !== 5'b0_0000) begin
      errors++; $display("FAIL hold_due: got %b want %b", {switch_out, schedule}, 5'b0);
    end
    tick();
    hold = 1'b0;
    #1;
    checks++;
    if ({switch_out, schedule} !== 5'b1_0100) begin
      errors++; $display("FAIL hold_release: got %b want %b", {switch_out, schedule}, 5'b1_0100);
    end
    // Reset in the middle of the switch pulse.
    reset = 1'b1;
    #1;
    checks++;
    if ({switch_out, schedule, cur_thr} !== 9'b0_0000_0000) begin
      errors++; $display("FAIL reset_mid: got %b want %b", {switch_out, schedule, cur_thr}, 9'b0);
    end
    tick();
    reset = 1'b0;
    set_st(THRFSM_RDY, THRFSM_RDY, THRFSM_IDLE, THRFSM_IDLE);
    checks++;
    if ({switch_out, schedule} !== 5'b0_0001) begin
      errors++; $display("FAIL reset_ptr: got %b want %b", {switch_out, schedule}, 5'b0_0001);
    end
    tick();
    checks++;
    if (cur_thr !== 4'b0001) begin
      errors++; $display("FAIL reset_cur_after: got %b want %b", cur_thr, 4'b0001);
    end
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    st0 = THRFSM_IDLE; st1 = THRFSM_IDLE; st2 = THRFSM_IDLE; st3 = THRFSM_IDLE;
    #1;
    test_reset();
    test_idle_pick();
    test_quantum();
    test_spec_pref();
    test_round_robin();
    test_hold_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
